// File: rtl/uart_transmitter.sv
// UART transmitter: LSB-first serialiser with req/ack capture, one start and one stop bit.
// Define UART_TX_PARITY_EN to add an even parity bit after the MSB.
module uart_transmitter #(
    parameter int SYS_FREQ       = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int CLOCK          = SYS_FREQ / BAUD_RATE,
    parameter int DATA_SIZE      = 8,
    parameter int BAUD_CNT_SIZE  = $clog2(CLOCK),
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 send_req,
    output logic                 send_ack,
    output logic                 busy,
    output logic                 tx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [BAUD_CNT_SIZE-1:0]  BAUD_LAST = BAUD_CNT_SIZE'(CLOCK - 1);
    localparam logic [BAUD_CNT_SIZE-1:0]  BAUD_ONE  = BAUD_CNT_SIZE'(1);
    localparam logic [BAUD_CNT_SIZE-1:0]  BAUD_ZERO = {BAUD_CNT_SIZE{1'b0}};
    localparam logic [BIT_COUNT_SIZE-1:0] BIT_LAST  = BIT_COUNT_SIZE'(DATA_SIZE - 1);
    localparam logic [BIT_COUNT_SIZE-1:0] BIT_ONE   = BIT_COUNT_SIZE'(1);
    localparam logic [BIT_COUNT_SIZE-1:0] BIT_ZERO  = {BIT_COUNT_SIZE{1'b0}};

    state_t                    state_r, state_next;
    logic [BAUD_CNT_SIZE-1:0]  baud_cnt_r, baud_cnt_next;
    logic [BIT_COUNT_SIZE-1:0] bit_cnt_r, bit_cnt_next;
    logic [DATA_SIZE-1:0]      shift_r, shift_next;
    logic                      tx_r, tx_next;
    logic                      ack_r, ack_next;
    logic                      busy_r, busy_next;
    logic                      baud_end;
`ifdef UART_TX_PARITY_EN
    logic                      parity_r, parity_next;
`endif

    assign baud_end = (baud_cnt_r == BAUD_LAST);
    assign tx       = tx_r;
    assign send_ack = ack_r;
    assign busy     = busy_r;

    // State, counters and registered line outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {DATA_SIZE{1'b0}};
            tx_r       <= 1'b1;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_next;
            baud_cnt_r <= baud_cnt_next;
            bit_cnt_r  <= bit_cnt_next;
            shift_r    <= shift_next;
            tx_r       <= tx_next;
            ack_r      <= ack_next;
            busy_r     <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_next;
`endif
        end
    end

    // Next-state logic; tx is precomputed so the line value changes on the same edge as the state
    always_comb begin
        state_next    = state_r;
        baud_cnt_next = baud_end ? BAUD_ZERO : (baud_cnt_r + BAUD_ONE);
        bit_cnt_next  = bit_cnt_r;
        shift_next    = shift_r;
        tx_next       = tx_r;
        ack_next      = 1'b0;
        busy_next     = busy_r;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                baud_cnt_next = BAUD_ZERO;
                tx_next       = 1'b1;
                if (send_req) begin
                    shift_next  = din;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^din;
`endif
                    ack_next    = 1'b1;
                    busy_next   = 1'b1;
                    tx_next     = 1'b0;
                    state_next  = START;
                end else begin
                    busy_next   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next   = DATA;
                    bit_cnt_next = BIT_ZERO;
                    tx_next      = shift_r[0];
                end else begin
                    tx_next      = 1'b0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_next = shift_r >> 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_r;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_r + BIT_ONE;
                        tx_next      = shift_next[0];
                    end
                end else begin
                    tx_next = shift_r[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    tx_next    = parity_r;
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    busy_next  = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = BAUD_ZERO;
                tx_next       = 1'b1;
                busy_next     = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

- Serialises parallel words onto a UART line: 8N1 framing by default, LSB first, one start bit and one stop bit.
- Optional even parity bit, selected at compile time.
- Transmit-side counterpart to the UART receiver; shares its `SYS_FREQ`/`BAUD_RATE` parameterisation and its req/ack parallel handshake.
- Sits between a host-side producer (register block or FIFO) and the `tx` pad.

## Interface
- `SYS_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `CLOCK`, `SYS_FREQ/BAUD_RATE`: clk cycles per bit. Legal range is ≥ 2; may be overridden directly in simulation.
- `DATA_SIZE`, 8: data bits per frame.
- `BAUD_CNT_SIZE`, `$clog2(CLOCK)`: baud counter width.
- `BIT_COUNT_SIZE`, `$clog2(DATA_SIZE+1)`: data bit counter width.
- `clk`  input  1  system clock; all logic is rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `din`  input  `DATA_SIZE`  word to send. Must be stable while `send_req` is high.
- `send_req`  input  1  request to send `din`. Held high until `send_ack` is seen, then dropped.
- `send_ack`  output  1  one-cycle pulse: `din` has been captured.
- `busy`  output  1  high from capture until the end of the stop bit.
- `tx`  output  1  serial line; idles high. Registered output.

## Operation
- **Reset values:** `tx`=1, `send_ack`=0, `busy`=0, state IDLE, all counters 0, shift register 0.
- **States:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:** `tx`=1. When `send_req`=1 is sampled: capture `din` into the shift register, pulse `send_ack`, set `busy`, enter START.
- **START:** `tx`=0 for `CLOCK` cycles.
- **DATA:** `tx` = shift register bit 0 for `CLOCK` cycles, then shift right. Bit counter runs 0..`DATA_SIZE`-1. After the last bit, enter PARITY (macro defined) or STOP.
- **PARITY:** `tx` = XOR of the captured word (even parity) for `CLOCK` cycles.
- **STOP:** `tx`=1 for `CLOCK` cycles, then go to IDLE and clear `busy`.
- **Baud counter:** counts 0..`CLOCK`-1 within each bit. It clears on every state change and on the final count, and wraps without overflow.
- **Bit counter:** clears on entry to DATA.
- `din` and `send_req` are ignored outside IDLE. Changing `din` after `send_ack` has no effect on the frame in flight.
- **Requester rule:** drop `send_req` in the cycle after `send_ack`. If `send_req` is still high when the block next returns to IDLE, that is treated as a new request.
- **Reset mid-frame:** `tx` returns to 1 asynchronously and the frame is abandoned (truncated on the line). No `send_ack` is issued for a request pending at reset.

## Timing
- `send_req` is sampled high in IDLE at edge t. At edge t: `send_ack`=1, `busy`=1, `tx`=0.
- At edge t+1: `send_ack`=0.
- Each line bit lasts exactly `CLOCK` cycles.
- Frame length: (2+`DATA_SIZE`)×`CLOCK` cycles, or (3+`DATA_SIZE`)×`CLOCK` with parity.
- The stop bit ends at edge t+frame length, where `busy`→0 and the state is IDLE.
- Earliest next capture: one cycle later. Minimum inter-frame idle is therefore 1 clk.
- No combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and each frame carries an even parity bit after the MSB.
- Undefined: no PARITY state, 8N1 framing only.
- The macro must match the receiver's parity setting.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles → `tx`=1, `busy`=0, `send_ack`=0 throughout and after release with `send_req`=0.
- **Single frame** (`CLOCK`=16, `din`=8'hA5, no parity):
  - `send_req` sampled high → `send_ack` is a single pulse.
  - `tx` sequence, 16 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` falls exactly 160 cycles after capture.
- **Parity** (`UART_TX_PARITY_EN`, `CLOCK`=16):
  - `din`=8'h07 → parity bit 1; frame length 176 cycles.
  - `din`=8'hA5 → parity bit 0.
- **Back-to-back:** `send_req` held high across two words 8'h55 then 8'hFF (`din` updated after the first ack).
  - Expect two acks 161 cycles apart.
  - Expect exactly 1 idle-high cycle between the stop bit and the next start bit.
- **Ignored inputs:** change `din` and toggle `send_req` during DATA → frame content unchanged and no extra `send_ack`.
- **Reset mid-frame:** assert `reset` during bit 3 of 8'h00 → `tx`=1 immediately and `busy`=0. After release, a new 8'h3C frame is sent correctly with a fresh `send_ack`.
